// File: rtl/sd_uart_pkg.sv
// Shared definitions for the SD host controller UART link: framing constants,
// command codes, framer state encoding and the checksum helper.
package sd_uart_pkg;

    localparam logic [7:0] START_BYTE        = 8'hA5;

    localparam logic [7:0] CMD_RESET         = 8'h20;
    localparam logic [7:0] CMD_STOP          = 8'h25;
    localparam logic [7:0] CMD_WRITE         = 8'h4A;
    localparam logic [7:0] CMD_READ          = 8'h7A;
    localparam logic [7:0] CMD_ERASE         = 8'hF0;
    localparam logic [7:0] CMD_GET_SD_INFO   = 8'h15;
    localparam logic [7:0] CMD_GET_CTRL_INFO = 8'h1B;

    typedef enum logic [2:0] {
        FS_IDLE       = 3'd0,
        FS_SEND_START = 3'd1,
        FS_SEND_CMD   = 3'd2,
        FS_SEND_LEN   = 3'd3,
        FS_SEND_DATA  = 3'd4,
        FS_SEND_CSUM  = 3'd5
    } framer_state_e;

    // Running frame checksum: plain XOR of every byte after the start byte.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/sd_uart_resp_framer_if.sv
// Request/response and UART TX byte-port bundle between the command
// controller, the response framer and the UART transmitter.
interface sd_uart_resp_framer_if #(
    parameter int MAX_BYTES = 16,
    parameter int LEN_W     = $clog2(MAX_BYTES + 1)
);
    logic [1:0]             req;
    logic [7:0]             req0_cmd;
    logic [7:0]             req1_cmd;
    logic [LEN_W-1:0]       req0_len;
    logic [LEN_W-1:0]       req1_len;
    logic [8*MAX_BYTES-1:0] req0_data;
    logic [8*MAX_BYTES-1:0] req1_data;
    logic [1:0]             ack;
    logic                   tx_ready;
    logic                   tx_en;
    logic [7:0]             tx_data;
    logic                   busy;
    logic                   done;

    modport master (
        output req, req0_cmd, req1_cmd, req0_len, req1_len, req0_data, req1_data, tx_ready,
        input  ack, tx_en, tx_data, busy, done
    );

    modport slave (
        input  req, req0_cmd, req1_cmd, req0_len, req1_len, req0_data, req1_data, tx_ready,
        output ack, tx_en, tx_data, busy, done
    );
endinterface

// File: rtl/sd_uart_rr_arb.sv
// Two-way round-robin arbiter: one-hot grant while enabled, ties go to the
// port that did not win last time. Port 0 wins the first tie after reset.
module sd_uart_rr_arb (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic [1:0] grant
);
    logic       last_r;
    logic [1:0] grant_s;

    // Pick a winner; a lone requester wins outright
    always_comb begin
        grant_s = 2'b00;
        if (grant_en) begin
            case (req)
                2'b01:   grant_s = 2'b01;
                2'b10:   grant_s = 2'b10;
                2'b11:   grant_s = last_r ? 2'b01 : 2'b10;
                default: grant_s = 2'b00;
            endcase
        end else begin
            grant_s = 2'b00;
        end
    end

    assign grant = grant_s;

    // Track the most recent winner for tie-breaking
    always_ff @(posedge clk) begin
        if (reset) begin
            last_r <= 1'b1;
        end else if (grant_s != 2'b00) begin
            last_r <= grant_s[1];
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/sd_uart_resp_framer.sv
// UART response framer: arbitrates two requesters and emits
// A5, cmd, len, payload MSB-first, XOR checksum over the TX byte port.
module sd_uart_resp_framer
    import sd_uart_pkg::*;
#(
    parameter int MAX_BYTES = 16,
    parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input logic                  clk,
    input logic                  reset,
    sd_uart_resp_framer_if.slave bus
);
    localparam int DATA_W = 8 * MAX_BYTES;

    localparam logic [2:0] ST_IDLE       = FS_IDLE;
    localparam logic [2:0] ST_SEND_START = FS_SEND_START;
    localparam logic [2:0] ST_SEND_CMD   = FS_SEND_CMD;
    localparam logic [2:0] ST_SEND_LEN   = FS_SEND_LEN;
    localparam logic [2:0] ST_SEND_DATA  = FS_SEND_DATA;
    localparam logic [2:0] ST_SEND_CSUM  = FS_SEND_CSUM;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_BYTES);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1'b1);

    logic [2:0]        state_r;
    logic [2:0]        state_s;
    logic [1:0]        grant_s;
    logic              grant_en_s;
    logic              xfer_s;
    logic              load_s;
    logic              shift_s;

    logic [7:0]        cmd_r;
    logic [LEN_W-1:0]  len_r;
    logic [DATA_W-1:0] data_r;
    logic [LEN_W-1:0]  idx_r;
    logic [LEN_W-1:0]  idx_s;
    logic [7:0]        csum_r;
    logic [7:0]        csum_s;

    logic [1:0]        ack_r;
    logic [1:0]        ack_s;
    logic              tx_en_r;
    logic              tx_en_s;
    logic [7:0]        tx_data_r;
    logic [7:0]        tx_data_s;
    logic              busy_r;
    logic              done_r;
    logic              done_s;

    logic [7:0]        cmd_sel_s;
    logic [LEN_W-1:0]  len_sel_s;
    logic [LEN_W-1:0]  len_clamp_s;
    logic [DATA_W-1:0] data_sel_s;
    logic [7:0]        len_byte_s;
    logic [7:0]        payload_s;
    logic [7:0]        csum_next_s;

    assign grant_en_s = (state_r == ST_IDLE);

    sd_uart_rr_arb u_arb (
        .clk      (clk),
        .reset    (reset),
        .req      (bus.req),
        .grant_en (grant_en_s),
        .grant    (grant_s)
    );

    assign cmd_sel_s   = grant_s[1] ? bus.req1_cmd  : bus.req0_cmd;
    assign len_sel_s   = grant_s[1] ? bus.req1_len  : bus.req0_len;
    assign data_sel_s  = grant_s[1] ? bus.req1_data : bus.req0_data;
    assign len_clamp_s = (len_sel_s > LEN_MAX) ? LEN_MAX : len_sel_s;

    assign xfer_s      = tx_en_r && bus.tx_ready;
    assign len_byte_s  = 8'(len_r);
    // Payload is shifted left as it goes out, so the next byte is always on top
    assign payload_s   = data_r[DATA_W-1 -: 8];
    assign csum_next_s = csum_add(csum_r, tx_data_r);

    // Next-state and next-output decode
    always_comb begin
        state_s   = state_r;
        ack_s     = 2'b00;
        tx_en_s   = tx_en_r;
        tx_data_s = tx_data_r;
        done_s    = 1'b0;
        csum_s    = csum_r;
        idx_s     = idx_r;
        load_s    = 1'b0;
        shift_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                tx_en_s = 1'b0;
                if (grant_s != 2'b00) begin
                    ack_s   = grant_s;
                    load_s  = 1'b1;
                    csum_s  = 8'h00;
                    idx_s   = '0;
                    state_s = ST_SEND_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND_START: begin
                // First cycle after the grant only raises tx_en with the start byte
                if (!tx_en_r) begin
                    tx_en_s   = 1'b1;
                    tx_data_s = START_BYTE;
                end else if (bus.tx_ready) begin
                    tx_data_s = cmd_r;
                    state_s   = ST_SEND_CMD;
                end else begin
                    state_s   = ST_SEND_START;
                end
            end
            ST_SEND_CMD: begin
                if (xfer_s) begin
                    csum_s    = csum_next_s;
                    tx_data_s = len_byte_s;
                    state_s   = ST_SEND_LEN;
                end else begin
                    state_s   = ST_SEND_CMD;
                end
            end
            ST_SEND_LEN: begin
                if (xfer_s) begin
                    csum_s = csum_next_s;
                    if (len_r != '0) begin
                        tx_data_s = payload_s;
                        shift_s   = 1'b1;
                        state_s   = ST_SEND_DATA;
                    end else begin
                        tx_data_s = csum_next_s;
                        state_s   = ST_SEND_CSUM;
                    end
                end else begin
                    state_s = ST_SEND_LEN;
                end
            end
            ST_SEND_DATA: begin
                if (xfer_s) begin
                    csum_s = csum_next_s;
                    if (idx_r == (len_r - LEN_ONE)) begin
                        tx_data_s = csum_next_s;
                        state_s   = ST_SEND_CSUM;
                    end else begin
                        tx_data_s = payload_s;
                        shift_s   = 1'b1;
                        idx_s     = idx_r + LEN_ONE;
                        state_s   = ST_SEND_DATA;
                    end
                end else begin
                    state_s = ST_SEND_DATA;
                end
            end
            ST_SEND_CSUM: begin
                if (xfer_s) begin
                    tx_en_s = 1'b0;
                    done_s  = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_SEND_CSUM;
                end
            end
            default: begin
                tx_en_s = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // Frame state and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            ack_r     <= 2'b00;
            tx_en_r   <= 1'b0;
            tx_data_r <= 8'h00;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            csum_r    <= 8'h00;
            idx_r     <= '0;
        end else begin
            state_r   <= state_s;
            ack_r     <= ack_s;
            tx_en_r   <= tx_en_s;
            tx_data_r <= tx_data_s;
            busy_r    <= (state_s != ST_IDLE);
            done_r    <= done_s;
            csum_r    <= csum_s;
            idx_r     <= idx_s;
        end
    end

    // Captured request fields; payload register doubles as the output shifter
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_r  <= 8'h00;
            len_r  <= '0;
            data_r <= '0;
        end else if (load_s) begin
            cmd_r  <= cmd_sel_s;
            len_r  <= len_clamp_s;
            data_r <= data_sel_s;
        end else if (shift_s) begin
            cmd_r  <= cmd_r;
            len_r  <= len_r;
            data_r <= {data_r[DATA_W-9:0], 8'h00};
        end else begin
            cmd_r  <= cmd_r;
            len_r  <= len_r;
            data_r <= data_r;
        end
    end

    assign bus.ack     = ack_r;
    assign bus.tx_en   = tx_en_r;
    assign bus.tx_data = tx_data_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;

endmodule

// File: tb/tb_sd_uart_resp_framer.sv
// Randomized bench for sd_uart_resp_framer: a queue-based frame model predicts
// ack/tx/busy/done every cycle; a few literal expectations pin the model.
module tb_sd_uart_resp_framer;
    import sd_uart_pkg::*;

    localparam int MB = 16;
    localparam int LW = $clog2(MB + 1);

    typedef logic [7:0] bq_t [$];

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    sd_uart_resp_framer_if #(.MAX_BYTES(MB), .LEN_W(LW)) bus ();
    sd_uart_resp_framer #(.MAX_BYTES(MB), .LEN_W(LW)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame as defined by the protocol: start, cmd, clamped len, payload, XOR
    function automatic bq_t make_frame(input logic [7:0] cmd, input logic [LW-1:0] len,
                                       input logic [8*MB-1:0] data);
        bq_t q;
        int n;
        logic [7:0] cs;
        logic [7:0] b;
        n = (int'(len) > MB) ? MB : int'(len);
        cs = cmd ^ 8'(n);
        q.push_back(START_BYTE);
        q.push_back(cmd);
        q.push_back(8'(n));
        for (int k = 0; k < n; k++) begin
            b = data[8*MB-1-8*k -: 8];
            q.push_back(b);
            cs = cs ^ b;
        end
        q.push_back(cs);
        return q;
    endfunction

    // Model state and the expectations for the current cycle
    int         m_phase = 0;
    bit         m_last = 1'b1;
    bit         model_on = 1'b0;
    bq_t        m_q;
    logic [1:0] e_ack = 2'b00;
    logic       e_en = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_dchk = 1'b0;
    logic [7:0] e_data = 8'h00;

    always @(negedge clk) begin
        int w;
        if (model_on) begin
            check("ack", 32'(bus.ack), 32'(e_ack));
            check("tx_en", 32'(bus.tx_en), 32'(e_en));
            check("busy", 32'(bus.busy), 32'(e_busy));
            check("done", 32'(bus.done), 32'(e_done));
            if (e_dchk) check("tx_data", 32'(bus.tx_data), 32'(e_data));
        end
        e_ack = 2'b00;
        e_done = 1'b0;
        if (reset) begin
            m_phase = 0; m_last = 1'b1; m_q.delete();
            e_en = 1'b0; e_busy = 1'b0; e_data = 8'h00; e_dchk = 1'b1;
            model_on = 1'b1;
        end else begin
            e_dchk = 1'b0;
            case (m_phase)
                0: begin
                    e_en = 1'b0;
                    e_busy = 1'b0;
                    if (bus.req != 2'b00) begin
                        if (bus.req == 2'b11) w = m_last ? 0 : 1;
                        else w = bus.req[0] ? 0 : 1;
                        m_last = (w == 1);
                        e_ack = (w == 1) ? 2'b10 : 2'b01;
                        m_q = (w == 1) ? make_frame(bus.req1_cmd, bus.req1_len, bus.req1_data)
                                       : make_frame(bus.req0_cmd, bus.req0_len, bus.req0_data);
                        e_busy = 1'b1;
                        m_phase = 1;
                    end
                end
                1: begin
                    m_phase = 2; e_en = 1'b1; e_busy = 1'b1; e_data = m_q[0]; e_dchk = 1'b1;
                end
                default: begin
                    e_dchk = 1'b1;
                    if (bus.tx_ready) begin
                        void'(m_q.pop_front());
                        if (m_q.size() == 0) begin
                            m_phase = 0; e_en = 1'b0; e_busy = 1'b0; e_done = 1'b1; e_dchk = 1'b0;
                        end else begin
                            e_data = m_q[0];
                        end
                    end
                end
            endcase
        end
    end

    // Observation log of DUT events (used for timing/order literals only)
    int  cyc = 0, ack_cyc = 0, done_cyc = 0, done_cnt = 0, xfer_cnt = 0;
    int  grants [$];
    bq_t obs;

    always @(negedge clk) begin
        cyc++;
        if (bus.ack == 2'b01) begin ack_cyc = cyc; grants.push_back(0); end
        else if (bus.ack == 2'b10) begin ack_cyc = cyc; grants.push_back(1); end
        if (bus.done) begin done_cyc = cyc; done_cnt++; end
        if (bus.tx_en && bus.tx_ready) begin xfer_cnt++; obs.push_back(bus.tx_data); end
    end

    // Requesters drop their request once acknowledged
    always @(posedge clk) begin
        #1;
        if (bus.ack[0]) bus.req[0] = 1'b0;
        if (bus.ack[1]) bus.req[1] = 1'b0;
    end

    bit rand_ready = 1'b0;
    always @(posedge clk) begin
        #1;
        bus.tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic raise(input int port, input logic [7:0] cmd, input logic [LW-1:0] len,
                         input logic [8*MB-1:0] data);
        if (port == 0) begin
            bus.req0_cmd = cmd; bus.req0_len = len; bus.req0_data = data; bus.req[0] = 1'b1;
        end else begin
            bus.req1_cmd = cmd; bus.req1_len = len; bus.req1_data = data; bus.req[1] = 1'b1;
        end
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (bus.req == 2'b00 && m_phase == 0) begin ok = 1'b1; break; end
        end
        if (!ok) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        @(posedge clk); #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [8*MB-1:0] d;
        bq_t fr;
        int s0, dn0;
        bit ok;
        d = 128'h0123456789ABCDEFFEDCBA9876543210;
        reset = 1'b1;
        bus.req = 2'b00;
        bus.req0_cmd = 8'h00; bus.req1_cmd = 8'h00;
        bus.req0_len = '0; bus.req1_len = '0;
        bus.req0_data = '0; bus.req1_data = '0;
        bus.tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("rst_tx_en", 32'(bus.tx_en), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'h00);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_busy_done", 32'({bus.busy, bus.done}), 32'd0);

        fr = make_frame(CMD_GET_SD_INFO, LW'(16), d);
        check("pin_f1_size", 32'(fr.size()), 32'd20);
        check("pin_f1_b3", 32'(fr[3]), 32'h01);
        check("pin_f1_csum", 32'(fr[19]), 32'h05);
        fr = make_frame(CMD_RESET, LW'(0), d);
        check("pin_f2_size", 32'(fr.size()), 32'd4);
        check("pin_f2_csum", 32'(fr[3]), 32'h20);
        fr = make_frame(CMD_READ, LW'(31), d);
        check("pin_f3_len", 32'(fr[2]), 32'h10);

        @(posedge clk); #2 raise(0, CMD_GET_SD_INFO, LW'(16), d);
        wait_idle("t1");
        @(negedge clk); #1;
        check("t1_done_lat", 32'(done_cyc - ack_cyc), 32'd21);

        @(posedge clk); #2 raise(1, CMD_RESET, LW'(0), d);
        wait_idle("t2");
        @(negedge clk); #1;
        check("t2_done_lat", 32'(done_cyc - ack_cyc), 32'd5);

        do_reset();
        grants.delete();
        @(posedge clk); #2 raise(0, CMD_WRITE, LW'(2), d); raise(1, CMD_ERASE, LW'(1), ~d);
        wait_idle("t3a");
        @(posedge clk); #2 raise(0, CMD_WRITE, LW'(0), d); raise(1, CMD_ERASE, LW'(3), ~d);
        wait_idle("t3b");
        check("t3_ngrants", 32'(grants.size()), 32'd4);
        if (grants.size() == 4) begin
            check("t3_order", 32'({grants[0][1:0], grants[1][1:0], grants[2][1:0], grants[3][1:0]}),
                  32'b00_01_00_01);
        end

        rand_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            int m;
            m = $urandom_range(1, 3);
            @(posedge clk); #2;
            if (m[0]) raise(0, 8'($urandom), LW'($urandom_range(0, 31)),
                            {$urandom, $urandom, $urandom, $urandom});
            if (m[1]) raise(1, 8'($urandom), LW'($urandom_range(0, 31)),
                            {$urandom, $urandom, $urandom, $urandom});
            wait_idle("rand");
        end

        obs.delete();
        @(posedge clk); #2 raise(0, CMD_READ, LW'(31), d);
        wait_idle("t5");
        check("t5_nbytes", 32'(obs.size()), 32'd20);
        if (obs.size() == 20) check("t5_lenbyte", 32'(obs[2]), 32'h10);

        rand_ready = 1'b0;
        s0 = xfer_cnt;
        @(posedge clk); #2 raise(0, CMD_WRITE, LW'(8), d);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (xfer_cnt >= s0 + 5) begin ok = 1'b1; break; end
        end
        if (!ok) check("t6_timeout", 32'd0, 32'd1);
        dn0 = done_cnt;
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #2 reset = 1'b0;
        repeat (15) @(posedge clk);
        check("t6_no_done", 32'(done_cnt), 32'(dn0));
        obs.delete();
        @(posedge clk); #2 raise(1, CMD_ERASE, LW'(3), ~d);
        wait_idle("t6b");
        check("t6_nbytes", 32'(obs.size()), 32'd7);
        if (obs.size() == 7) check("t6_start", 32'(obs[0]), 32'hA5);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
